// File: rtl/output_calc_pkg.sv
// Shared definitions for the multi-lane FP16 output projection: FSM states,
// the FP16 zero constant and the sweep-length / done-latency helpers.
package output_calc_pkg;

    typedef enum logic [2:0] {
        ST_WARM,
        ST_IDLE,
        ST_CALC,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    // A sweep must be long enough that no accumulator is re-read before its
    // pending write-back has landed.
    function automatic int unsigned calc_sweep_len(input int unsigned elems,
                                                   input int unsigned a_lat);
        return (elems > a_lat) ? elems : a_lat + 1;
    endfunction

    function automatic int unsigned calc_done_cycle(input int unsigned ns,
                                                    input int unsigned s,
                                                    input int unsigned m_lat,
                                                    input int unsigned a_lat);
        return ns * s + m_lat + a_lat + 3;
    endfunction

endpackage

// File: rtl/fp16_add_wrapper.sv
// Pipelined FP16 adder, round-to-nearest-even, subnormals flushed to zero.
module fp16_add_wrapper #(
    parameter int LAT = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        valid_i,
    output logic [15:0] result_o,
    output logic        valid_o
);

    logic [15:0]    data_q [LAT];
    logic [LAT-1:0] vld_q;

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [13:0] mx, my;
        logic [27:0] sh;
        logic [14:0] sum;
        logic [10:0] mant;
        logic        g, st;
        int          e, d;
        if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0))
            return 16'h7E00;
        if (a[14:10] == 5'h1F && b[14:10] == 5'h1F && a[15] != b[15]) return 16'h7E00;
        if (a[14:10] == 5'h1F) return a;
        if (b[14:10] == 5'h1F) return b;
        if (a[14:10] == 5'd0 && b[14:10] == 5'd0) return {a[15] & b[15], 15'h0000};
        if (a[14:10] == 5'd0) return b;
        if (b[14:10] == 5'd0) return a;
        // Larger magnitude first so the aligned subtraction never goes negative.
        if (b[14:0] > a[14:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        mx = {1'b1, x[9:0], 3'b000};
        my = {1'b1, y[9:0], 3'b000};
        d  = int'(x[14:10]) - int'(y[14:10]);
        if (d > 13) begin
            my = 14'd1;
        end else begin
            sh = {my, 14'd0} >> d;
            my = sh[27:14] | {13'd0, |sh[13:0]};
        end
        e = int'(x[14:10]);
        if (x[15] == y[15]) sum = {1'b0, mx} + {1'b0, my};
        else                sum = {1'b0, mx} - {1'b0, my};
        if (sum == 15'd0) return 16'h0000;
        if (sum[14]) begin
            sum = {1'b0, sum[14:2], sum[1] | sum[0]};
            e   = e + 1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!sum[13]) begin
                    sum = sum << 1;
                    e   = e - 1;
                end
            end
        end
        mant = {1'b0, sum[12:3]};
        g    = sum[2];
        st   = |sum[1:0];
        if (g && (st || mant[0])) mant = mant + 11'd1;
        if (mant[10]) begin
            mant = 11'd0;
            e    = e + 1;
        end
        if (e >= 31) return {x[15], 5'h1F, 10'h000};
        if (e <= 0) return {x[15], 15'h0000};
        return {x[15], e[4:0], mant[9:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= fp16_add(a_i, b_i);
        for (int i = 1; i < LAT; i++) data_q[i] <= data_q[i-1];
    end

    assign result_o = data_q[LAT-1];
    assign valid_o  = vld_q[LAT-1];

endmodule

// File: rtl/fp16_mult_wrapper.sv
// Pipelined FP16 multiplier, round-to-nearest-even, subnormals flushed to zero.
module fp16_mult_wrapper #(
    parameter int LAT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        valid_i,
    output logic [15:0] result_o,
    output logic        valid_o
);

    logic [15:0]    data_q [LAT];
    logic [LAT-1:0] vld_q;

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [4:0]  ea, eb;
        logic [9:0]  ma, mb;
        logic [21:0] prod;
        logic [10:0] mant;
        logic        g, st;
        int          e;
        s  = a[15] ^ b[15];
        ea = a[14:10];
        eb = b[14:10];
        ma = a[9:0];
        mb = b[9:0];
        if ((ea == 5'h1F && ma != 10'd0) || (eb == 5'h1F && mb != 10'd0)) return 16'h7E00;
        if (ea == 5'h1F || eb == 5'h1F) begin
            if (ea == 5'd0 || eb == 5'd0) return 16'h7E00;
            return {s, 5'h1F, 10'h000};
        end
        if (ea == 5'd0 || eb == 5'd0) return {s, 15'h0000};
        prod = {11'd0, 1'b1, ma} * {11'd0, 1'b1, mb};
        e    = int'(ea) + int'(eb) - 15;
        if (prod[21]) begin
            mant = {1'b0, prod[20:11]};
            g    = prod[10];
            st   = |prod[9:0];
            e    = e + 1;
        end else begin
            mant = {1'b0, prod[19:10]};
            g    = prod[9];
            st   = |prod[8:0];
        end
        if (g && (st || mant[0])) mant = mant + 11'd1;
        if (mant[10]) begin
            mant = 11'd0;
            e    = e + 1;
        end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[4:0], mant[9:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= fp16_mul(a_i, b_i);
        for (int i = 1; i < LAT; i++) data_q[i] <= data_q[i-1];
    end

    assign result_o = data_q[LAT-1];
    assign valid_o  = vld_q[LAT-1];

endmodule

// File: rtl/output_calc_lane.sv
// One mul/add lane: multiplies issued operands, accumulates into acc[slot] and
// reports each write-back with the slot and last-sweep tag it was issued with.
module output_calc_lane
    import output_calc_pkg::*;
#(
    parameter int DW     = 16,
    parameter int E      = 8,
    parameter int SLOT_W = 3,
    parameter int M_LAT  = 6,
    parameter int A_LAT  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              issue_vld_i,
    input  logic              issue_last_i,
    input  logic [SLOT_W-1:0] issue_slot_i,
    input  logic [DW-1:0]     a_i,
    input  logic [DW-1:0]     b_i,
    output logic              wb_vld_o,
    output logic              wb_last_o,
    output logic [SLOT_W-1:0] wb_slot_o,
    output logic [DW-1:0]     wb_data_o
);

    localparam int RD = M_LAT;
    localparam int WB = M_LAT + A_LAT;

    // Tag stage 0 is the issue itself; stage i is valid i cycles later.
    logic [WB:1]       tvld_q, tlast_q;
    logic [SLOT_W-1:0] tslot_q [1:WB];
    logic [DW-1:0]     acc_q   [E];
    logic [DW-1:0]     mul_res, add_res;
    logic              mul_vld, add_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvld_q  <= '0;
            tlast_q <= '0;
            for (int i = 1; i <= WB; i++) tslot_q[i] <= '0;
        end else begin
            tvld_q[1]  <= issue_vld_i;
            tlast_q[1] <= issue_last_i;
            tslot_q[1] <= issue_slot_i;
            for (int i = 2; i <= WB; i++) begin
                tvld_q[i]  <= tvld_q[i-1];
                tlast_q[i] <= tlast_q[i-1];
                tslot_q[i] <= tslot_q[i-1];
            end
        end
    end

    fp16_mult_wrapper #(.LAT(M_LAT)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_i  (issue_vld_i),
        .result_o (mul_res),
        .valid_o  (mul_vld)
    );

    fp16_add_wrapper #(.LAT(A_LAT)) u_add (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_i      (acc_q[tslot_q[RD]]),
        .b_i      (mul_res),
        .valid_i  (mul_vld),
        .result_o (add_res),
        .valid_o  (add_vld)
    );

    assign wb_vld_o  = add_vld && tvld_q[WB];
    assign wb_last_o = tlast_q[WB];
    assign wb_slot_o = tslot_q[WB];
    assign wb_data_o = add_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < E; i++) acc_q[i] <= FP16_ZERO;
        end else if (clr_i) begin
            for (int i = 0; i < E; i++) acc_q[i] <= FP16_ZERO;
        end else if (wb_vld_o) begin
            acc_q[tslot_q[WB]] <= add_res;
        end
    end

endmodule

// File: rtl/output_calc_lanes_fp16.sv
// Multi-lane FP16 output projection y = sum_n h*C (plus D*x when the
// OUTPUT_CALC_DSKIP_EN macro is defined); owns the FSM, counters and y register.
module output_calc_lanes_fp16
    import output_calc_pkg::*;
#(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int LANES = 2,
    parameter int M_LAT = 6,
    parameter int A_LAT = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [B*H*P*N*DW-1:0]   h_flat,
    input  logic [B*N*DW-1:0]       C_flat,
`ifdef OUTPUT_CALC_DSKIP_EN
    input  logic [H*DW-1:0]         D_flat,
    input  logic [B*H*P*DW-1:0]     x_flat,
`endif
    output logic [B*H*P*DW-1:0]     y_flat,
    output logic                    busy,
    output logic                    done
);

    localparam int EL     = B * H * P;
    localparam int E      = EL / LANES;
    localparam int S      = int'(calc_sweep_len(E, A_LAT));
`ifdef OUTPUT_CALC_DSKIP_EN
    localparam int NS     = N + 1;
`else
    localparam int NS     = N;
`endif
    localparam int DRAIN  = M_LAT + A_LAT + 2;
    localparam int K_W    = (S > 1) ? $clog2(S) : 1;
    localparam int NS_W   = (NS > 1) ? $clog2(NS) : 1;
    localparam int CNT_W  = $clog2(DRAIN);
    localparam int SLOT_W = (E > 1) ? $clog2(E) : 1;
    localparam int EW     = (EL > 1) ? $clog2(EL) : 1;

    localparam logic [K_W-1:0]   S_LAST   = K_W'(S - 1);
    localparam logic [K_W:0]     E_K      = (K_W + 1)'(E);
    localparam logic [NS_W-1:0]  NS_LAST  = NS_W'(NS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN - 1);

    if ((EL % LANES) != 0) begin : g_bad_lanes
        $error("B*H*P must be a multiple of LANES");
    end
    if (DW != 16) begin : g_bad_dw
        $error("only FP16 (DW=16) is supported");
    end

    state_e            state_q, state_d;
    logic [K_W-1:0]    slot_q, slot_d;
    logic [NS_W-1:0]   sweep_q, sweep_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clr;
    logic [DW-1:0]     y_q [EL];

    logic              wb_vld  [LANES];
    logic              wb_last [LANES];
    logic [SLOT_W-1:0] wb_slot [LANES];
    logic [DW-1:0]     wb_data [LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WARM;
            slot_q  <= '0;
            sweep_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sweep_q <= sweep_d;
            cnt_q   <= cnt_d;
        end
    end

    // WARM and FLUSH share one drain counter: both wait out the full mul+add pipe.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sweep_d = sweep_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        unique case (state_q)
            ST_WARM: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    clr     = 1'b1;
                    slot_d  = '0;
                    sweep_d = '0;
                end
            end
            ST_CALC: begin
                if (slot_q == S_LAST) begin
                    slot_d = '0;
                    if (sweep_q == NS_LAST) begin
                        state_d = ST_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_WARM;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DW-1:0]     op_a, op_b;
        logic              issue_vld;
        logic [SLOT_W-1:0] issue_slot;

        // Slots at or beyond E are padding: they keep the sweep long enough
        // for the hazard rule but never touch an accumulator.
        always_comb begin
            int e, bi;
`ifdef OUTPUT_CALC_DSKIP_EN
            int hi;
`endif
            op_a       = FP16_ZERO;
            op_b       = FP16_ZERO;
            issue_vld  = 1'b0;
            issue_slot = '0;
            e          = int'(slot_q) * LANES + l;
            bi         = 0;
`ifdef OUTPUT_CALC_DSKIP_EN
            hi         = 0;
`endif
            if (state_q == ST_CALC && {1'b0, slot_q} < E_K) begin
                issue_vld  = 1'b1;
                issue_slot = SLOT_W'(slot_q);
                bi         = e / (H * P);
                if (int'(sweep_q) < N) begin
                    op_a = h_flat[(e * N + int'(sweep_q)) * DW +: DW];
                    op_b = C_flat[(bi * N + int'(sweep_q)) * DW +: DW];
                end
`ifdef OUTPUT_CALC_DSKIP_EN
                else begin
                    hi   = (e / P) % H;
                    op_a = D_flat[hi * DW +: DW];
                    op_b = x_flat[e * DW +: DW];
                end
`endif
            end
        end

        output_calc_lane #(
            .DW     (DW),
            .E      (E),
            .SLOT_W (SLOT_W),
            .M_LAT  (M_LAT),
            .A_LAT  (A_LAT)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .clr_i        (clr),
            .issue_vld_i  (issue_vld),
            .issue_last_i (sweep_q == NS_LAST),
            .issue_slot_i (issue_slot),
            .a_i          (op_a),
            .b_i          (op_b),
            .wb_vld_o     (wb_vld[l]),
            .wb_last_o    (wb_last[l]),
            .wb_slot_o    (wb_slot[l]),
            .wb_data_o    (wb_data[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < EL; i++) y_q[i] <= FP16_ZERO;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (wb_vld[l] && wb_last[l])
                    y_q[EW'(int'(wb_slot[l]) * LANES + l)] <= wb_data[l];
            end
        end
    end

    always_comb begin
        y_flat = '0;
        for (int i = 0; i < EL; i++) y_flat[i*DW +: DW] = y_q[i];
    end

endmodule
